// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Round-robin arbiter that lets an instruction cache and a data cache
//   share one line-wide memory port. Only one transaction is in flight at
//   a time. Every transaction is followed by at least one IDLE cycle.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   i_read, i_addr        instruction-cache line read request (held until i_resp)
//   i_rdata, i_resp       instruction read data, one-cycle completion pulse
//   d_read, d_write       data-cache read / write request (held until d_resp)
//   d_addr, d_wdata       data-cache address and write line
//   d_rdata, d_resp       data read data, one-cycle completion pulse
//   pmem_*                shared memory port (strobes held until pmem_resp)
//   i_grants, d_grants    saturating counts of completed transactions
module mem_arbiter #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [31:0]       i_grants,
    output logic [31:0]       d_grants
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        last_d_q, last_d_d;     // 1: data side was served last
    logic [31:0] i_grants_q, i_grants_d;
    logic [31:0] d_grants_q, d_grants_d;

    logic i_pend, d_pend;

    assign i_pend   = i_read;
    assign d_pend   = d_read | d_write;

    assign i_rdata  = pmem_rdata;
    assign d_rdata  = pmem_rdata;
    assign i_grants = i_grants_q;
    assign d_grants = d_grants_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_d_q   <= 1'b0;
            i_grants_q <= '0;
            d_grants_q <= '0;
        end else begin
            state_q    <= state_d;
            last_d_q   <= last_d_d;
            i_grants_q <= i_grants_d;
            d_grants_q <= d_grants_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d_d   = last_d_q;
        i_grants_d = i_grants_q;
        d_grants_d = d_grants_q;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_addr  = '0;
        pmem_wdata = '0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // On a tie the side not served last wins; pmem_resp is ignored here.
                if (i_pend && d_pend) begin
                    state_d = last_d_q ? SERVE_I : SERVE_D;
                end else if (i_pend) begin
                    state_d = SERVE_I;
                end else if (d_pend) begin
                    state_d = SERVE_D;
                end
            end
            SERVE_I: begin
                pmem_read = 1'b1;
                pmem_addr = i_addr;
                if (pmem_resp) begin
                    i_resp     = 1'b1;
                    last_d_d   = 1'b0;
                    i_grants_d = (i_grants_q == '1) ? i_grants_q : i_grants_q + 32'd1;
                    state_d    = IDLE;
                end
            end
            SERVE_D: begin
                pmem_addr  = d_addr;
                pmem_wdata = d_wdata;
                pmem_write = d_write;
                pmem_read  = d_read & ~d_write;
                if (pmem_resp) begin
                    d_resp     = 1'b1;
                    last_d_d   = 1'b1;
                    d_grants_d = (d_grants_q == '1) ? d_grants_q : d_grants_q + 32'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- LINE_W, 256, cache line width in bits.
- ADDR_W, 32, address width in bits.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- i_read  in  1  instruction-cache line read request, held until i_resp.
- i_addr  in  ADDR_W  instruction line address.
- i_rdata  out  LINE_W  instruction line data.
- i_resp  out  1  one-cycle completion pulse to instruction cache.
- d_read  in  1  data-cache line read request, held until d_resp.
- d_write  in  1  data-cache line write request, held until d_resp.
- d_addr  in  ADDR_W  data line address.
- d_wdata  in  LINE_W  data line write data.
- d_rdata  out  LINE_W  data line read data.
- d_resp  out  1  one-cycle completion pulse to data cache.
- pmem_read  out  1  shared memory read strobe.
- pmem_write  out  1  shared memory write strobe.
- pmem_addr  out  ADDR_W  shared memory address.
- pmem_wdata  out  LINE_W  shared memory write data.
- pmem_rdata  in  LINE_W  shared memory read data.
- pmem_resp  in  1  shared memory completion, one cycle.
- i_grants  out  32  count of completed instruction transactions.
- d_grants  out  32  count of completed data transactions.

Function
REQ-003 FSM states SHALL be IDLE, SERVE_I, SERVE_D.

REQ-004 IDLE SHALL drive pmem_read=0, pmem_write=0, i_resp=0, d_resp=0.

REQ-005 Transitions out of IDLE SHALL be registered:
- Only i_read pending: next state SERVE_I.
- Only d_read|d_write pending: next state SERVE_D.
- Neither pending: remain in IDLE.

REQ-006 When both requesters are pending in IDLE, the arbiter SHALL grant the requester not served last (round-robin via 1-bit last_grant register); after reset, last_grant=I, so data wins the first tie.

REQ-007 SERVE_I SHALL drive pmem_read=1, pmem_write=0, pmem_addr=i_addr.

REQ-008 SERVE_D SHALL drive pmem_addr=d_addr, pmem_wdata=d_wdata, pmem_write=d_write, and pmem_read=d_read&~d_write (write wins if both are asserted).

REQ-009 i_rdata and d_rdata SHALL combinationally equal pmem_rdata at all times.

REQ-010 Completion handshake:
- In SERVE_x, pmem_resp=1 SHALL pulse x_resp combinationally in the same cycle.
- In the same cycle, it SHALL increment x_grants, update last_grant=x, and set the next state to IDLE.

REQ-011 Minimum turnaround: request to pmem strobe SHALL be 1 cycle; pmem_resp to x_resp SHALL be 0 cycles; back-to-back transactions SHALL have exactly one IDLE cycle between them.

REQ-012 In SERVE_x, strobes SHALL be held until pmem_resp regardless of requester deassertion; x_resp SHALL still pulse on completion.

REQ-013 pmem_resp received in IDLE SHALL be ignored (no resp pulse, no count change).

REQ-014 i_grants and d_grants SHALL saturate at 32'hFFFFFFFF (no wrap).

REQ-015 The non-served requester SHALL see resp=0 and has no effect on pmem_* outputs.

Reset
REQ-016 Asserting rst_n=0 at any time, including mid-transaction, SHALL immediately set state=IDLE, last_grant=I, i_grants=0, d_grants=0, and drop pmem_read/pmem_write/i_resp/d_resp to 0.

REQ-017 After rst_n deasserts, the arbiter SHALL evaluate requests on the first rising edge.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Single I read: i_read=1, i_addr=0x100, pmem_resp after 3 cycles with rdata=X -> pmem_read cycle 1..4, i_resp pulse cycle 4, i_rdata=X, i_grants=1.
- Tie after reset: i_read=d_read=1 in the same cycle -> SERVE_D first, then IDLE for 1 cycle, then SERVE_I; final d_grants=1, i_grants=1.
- Continuous contention: both requests re-raised after every resp for 6 transactions -> grant order D,I,D,I,D,I.
- Write precedence: d_read=d_write=1, d_addr=0x2000 -> pmem_write=1, pmem_read=0, pmem_addr=0x2000.
- Reset mid-SERVE_I: rst_n low for 1 cycle -> pmem_read=0 asynchronously, counters=0; a later pmem_resp in IDLE produces no resp.
- Saturation: preload/force i_grants=0xFFFFFFFE, complete 2 I transactions -> i_grants=0xFFFFFFFF.
